// File: rtl/lfsr_stream_if.sv
// Valid/ready word stream carrying LFSR output words from lfsr_stream to its consumer.
// A word transfers (fires) on any rising clock edge where o_valid and i_ready are both high.
interface lfsr_stream_if #(
  parameter int OUT_BITS = 1
);
  logic                o_valid;
  logic                i_ready;
  logic [OUT_BITS-1:0] o_data;

  modport master (output o_valid, output o_data, input  i_ready);
  modport slave  (input  o_valid, input  o_data, output i_ready);
endinterface

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR word source. Each accepted word advances the state by OUT_BITS shifts.
// Optional period-wrap pulse o_wrap is built only when LFSR_WRAP_DET_EN is defined.
module lfsr_stream #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 'hB8,
  parameter logic [WIDTH-1:0] SEED     = 'h01,
  parameter int               OUT_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  lfsr_stream_if.master    strm,
`ifdef LFSR_WRAP_DET_EN
  output logic             o_wrap,
`endif
  output logic             dbg_state,
  output logic [WIDTH-1:0] dbg_lfsr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lfsr_adv;
  logic [WIDTH-1:0] seed_eff;
  logic             fire;

  // OUT_BITS single shifts unrolled into one combinational step.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < OUT_BITS; i++) begin
      t = {t[WIDTH-2:0], ^(t & TAPS)};
    end
    return t;
  endfunction

  assign lfsr_adv = advance(lfsr_q);
  assign seed_eff = (i_seed == '0) ? SEED : i_seed;

  assign strm.o_valid = (state_q == RUN);
  assign strm.o_data  = lfsr_q[WIDTH-1 -: OUT_BITS];
  assign fire         = strm.o_valid & strm.i_ready;

  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr_q;

  // Load beats fire: a word offered in the load cycle is discarded without advancing.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    if (i_load) begin
      state_d = IDLE;
      lfsr_d  = seed_eff;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_en) state_d = RUN;
        end
        RUN: begin
          if (fire) begin
            lfsr_d  = lfsr_adv;
            state_d = i_en ? RUN : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
    end
  end

`ifdef LFSR_WRAP_DET_EN
  logic [WIDTH-1:0] last_seed;
  logic             wrap_q;

  // Period is complete when an advance lands back on the most recently loaded state.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_seed <= SEED;
      wrap_q    <= 1'b0;
    end else if (i_load) begin
      last_seed <= seed_eff;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q    <= fire && (lfsr_adv == last_seed);
    end
  end

  assign o_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: an OUT_BITS=1 and an OUT_BITS=8 instance share all inputs.
// Define LFSR_WRAP_DET_EN to also exercise the period-wrap pulse.
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] seed;
  logic       ready;

  int test_count = 0;
  int fail_count = 0;

  lfsr_stream_if #(.OUT_BITS(1)) s1 ();
  lfsr_stream_if #(.OUT_BITS(8)) s8 ();

  logic       st1, st8;
  logic [7:0] lf1, lf8;
`ifdef LFSR_WRAP_DET_EN
  logic       wrap1, wrap8;
`endif

  assign s1.i_ready = ready;
  assign s8.i_ready = ready;

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_BITS(1)) u1 (
    .clk(clk), .rst(rst), .i_en(en), .i_load(load), .i_seed(seed), .strm(s1),
`ifdef LFSR_WRAP_DET_EN
    .o_wrap(wrap1),
`endif
    .dbg_state(st1), .dbg_lfsr(lf1)
  );

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_BITS(8)) u8 (
    .clk(clk), .rst(rst), .i_en(en), .i_load(load), .i_seed(seed), .strm(s8),
`ifdef LFSR_WRAP_DET_EN
    .o_wrap(wrap8),
`endif
    .dbg_state(st8), .dbg_lfsr(lf8)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 8'h00; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    test_count++; if (s1.o_valid !== 1'b0) begin fail_count++; $display("FAIL reset_valid1: got %0b expected 0", s1.o_valid); end
    test_count++; if (s8.o_valid !== 1'b0) begin fail_count++; $display("FAIL reset_valid8: got %0b expected 0", s8.o_valid); end
    test_count++; if (lf1 !== 8'h01) begin fail_count++; $display("FAIL reset_state: got %0h expected 01", lf1); end
    test_count++; if (s8.o_data !== 8'h01) begin fail_count++; $display("FAIL reset_data8: got %0h expected 01", s8.o_data); end
    test_count++; if (st1 !== 1'b0) begin fail_count++; $display("FAIL reset_fsm: got %0b expected 0", st1); end
  endtask

  // OUT_BITS=1 sequence: states from seed 01, o_data is the state MSB.
  task automatic test_single_bit();
    logic [7:0] states [0:8];
    logic [7:0] cur;
    states = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    test_count++; if (s1.o_valid !== 1'b1) begin fail_count++; $display("FAIL sb_valid_rise: got %0b expected 1", s1.o_valid); end
    for (int k = 0; k < 8; k++) begin
      cur = states[k];
      test_count++; if (lf1 !== cur) begin fail_count++; $display("FAIL sb_state[%0d]: got %0h expected %0h", k, lf1, cur); end
      test_count++; if (s1.o_data !== cur[7]) begin fail_count++; $display("FAIL sb_data[%0d]: got %0b expected %0b", k, s1.o_data, cur[7]); end
      tick();
    end
    cur = states[8];
    test_count++; if (lf1 !== cur) begin fail_count++; $display("FAIL sb_state[8]: got %0h expected %0h", lf1, cur); end
  endtask

  task automatic test_word_and_hold();
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    test_count++; if (s8.o_data !== 8'h01 || s8.o_valid !== 1'b1) begin fail_count++; $display("FAIL w8_first: got %0h/%0b expected 01/1", s8.o_data, s8.o_valid); end
    tick();
    test_count++; if (s8.o_data !== 8'h1C) begin fail_count++; $display("FAIL w8_second: got %0h expected 1c", s8.o_data); end
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      test_count++; if (s8.o_data !== 8'h1C || s8.o_valid !== 1'b1) begin fail_count++; $display("FAIL w8_hold[%0d]: got %0h/%0b expected 1c/1", k, s8.o_data, s8.o_valid); end
    end
  endtask

  // Continues from the held 8'h1C word of test_word_and_hold.
  task automatic test_load();
    ready = 1'b1; load = 1'b1; seed = 8'h00;
    tick();
    load = 1'b0;
    test_count++; if (s8.o_valid !== 1'b0) begin fail_count++; $display("FAIL ld_valid_drop: got %0b expected 0", s8.o_valid); end
    test_count++; if (lf8 !== 8'h01) begin fail_count++; $display("FAIL ld_zero_seed_state: got %0h expected 01", lf8); end
    tick();
    test_count++; if (s8.o_valid !== 1'b1 || s8.o_data !== 8'h01) begin fail_count++; $display("FAIL ld_resume: got %0b/%0h expected 1/01", s8.o_valid, s8.o_data); end
    load = 1'b1; seed = 8'hA5;
    tick();
    load = 1'b0;
    test_count++; if (s8.o_valid !== 1'b0) begin fail_count++; $display("FAIL ld_a5_drop: got %0b expected 0", s8.o_valid); end
    tick();
    test_count++; if (s8.o_valid !== 1'b1 || s8.o_data !== 8'hA5) begin fail_count++; $display("FAIL ld_a5_word: got %0b/%0h expected 1/a5", s8.o_valid, s8.o_data); end
  endtask

  task automatic test_drop_en();
    do_reset();
    en = 1'b1; ready = 1'b0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      test_count++; if (s8.o_valid !== 1'b1 || s8.o_data !== 8'h01) begin fail_count++; $display("FAIL de_hold[%0d]: got %0b/%0h expected 1/01", k, s8.o_valid, s8.o_data); end
    end
    ready = 1'b1;
    tick();
    test_count++; if (s8.o_valid !== 1'b0) begin fail_count++; $display("FAIL de_idle: got %0b expected 0", s8.o_valid); end
    test_count++; if (lf8 !== 8'h1C) begin fail_count++; $display("FAIL de_advanced: got %0h expected 1c", lf8); end
    tick();
    tick();
    test_count++; if (lf8 !== 8'h1C || s8.o_valid !== 1'b0) begin fail_count++; $display("FAIL de_frozen: got %0h/%0b expected 1c/0", lf8, s8.o_valid); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en = 1'b1; ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    test_count++; if (s1.o_valid !== 1'b0 || lf1 !== 8'h01) begin fail_count++; $display("FAIL rst_mid: got %0b/%0h expected 0/01", s1.o_valid, lf1); end
    rst = 1'b0;
    tick();
    test_count++; if (s1.o_valid !== 1'b1 || lf1 !== 8'h01) begin fail_count++; $display("FAIL rst_mid_resume: got %0b/%0h expected 1/01", s1.o_valid, lf1); end
  endtask

`ifdef LFSR_WRAP_DET_EN
  task automatic test_wrap();
    int fires;
    int wraps;
    int first_at;
    int second_at;
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    test_count++; if (wrap1 !== 1'b0) begin fail_count++; $display("FAIL wr_idle: got %0b expected 0", wrap1); end
    fires = 0; wraps = 0; first_at = -1; second_at = -1;
    for (int k = 0; k < 520; k++) begin
      tick();
      fires++;
      if (wrap1 === 1'b1) begin
        wraps++;
        if (wraps == 1) first_at = fires;
        if (wraps == 2) second_at = fires;
      end
    end
    test_count++; if (first_at !== 255) begin fail_count++; $display("FAIL wr_first: got %0d expected 255", first_at); end
    test_count++; if (second_at !== 510) begin fail_count++; $display("FAIL wr_second: got %0d expected 510", second_at); end
    test_count++; if (wraps !== 2) begin fail_count++; $display("FAIL wr_count: got %0d expected 2", wraps); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_count++; if (wrap1 !== 1'b0 || s1.o_valid !== 1'b0 || lf1 !== 8'h01) begin fail_count++; $display("FAIL wr_reset: got %0b/%0b/%0h expected 0/0/01", wrap1, s1.o_valid, lf1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_bit();
    test_word_and_hold();
    test_load();
    test_drop_en();
    test_reset_mid_run();
`ifdef LFSR_WRAP_DET_EN
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
